encoder_8to3_scan: RTL and testbench
====================================

# encoder_8to3_scan

Sequential 8-to-3 priority encoder, the encoding counterpart of the combinational-assignment 3-to-8 decoder. It accepts an 8-bit request vector through a valid/ready handshake. It then emits the 3-bit index of every set bit, one index per transfer, in priority order, and marks the final index. It sits between request sources (interrupt lines, arbiter grants) and any consumer that needs binary indices instead of a bit vector.

## Interface
- `LSB_FIRST`, default 1: 1 = lowest set index emitted first; 0 = highest set index emitted first.

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in` holds a vector to encode
- `in_ready`  out  1  block can accept a vector this cycle
- `in`  in  8  request vector; bit k set means index k is requested
- `out_valid`  out  1  `out` holds a valid index
- `out_ready`  in  1  consumer takes `out` this cycle
- `out`  out  3  binary index of the current highest-priority pending bit
- `out_last`  out  1  current beat is the last beat for this vector
- `out_zero`  out  1  accepted vector was 8'b0; the beat carries no index

## Operation
- Two states: `IDLE` and `SCAN`. Internal register `pend[7:0]`.
- In `IDLE`:
  - `in_ready`=1.
  - When `in_valid`=1, the block captures `pend<=in`, sets the zero flag `<=(in==0)`, and moves to `SCAN`.
- In `SCAN`:
  - `in_ready`=0 and `out_valid`=1.
  - `out` is the priority index of `pend`, selected per `LSB_FIRST`.
  - `out_last`=1 when `pend` has exactly one bit set, or when the zero flag is set.
  - `out_zero` equals the zero flag.
- Transfer happens when `out_valid && out_ready`.
  - If `out_last`=0, the emitted bit of `pend` is cleared and the block stays in `SCAN`.
  - If `out_last`=1, `pend` is cleared and the block returns to `IDLE`.
- Zero vector: produces exactly one beat with `out`=3'b000, `out_last`=1, `out_zero`=1.
- A vector with N set bits (N≥1) produces exactly N beats, and no index is repeated.
- Backpressure: while `out_valid && !out_ready`, `out`, `out_last` and `out_zero` hold stable.
- While `out_valid`=0, `out`=3'b000, `out_last`=0 and `out_zero`=0.
- `in` is sampled only on the accept cycle; later changes to `in` have no effect.

## Timing
- Reset (`rst`=1 at an edge):
  - state=`IDLE`, `pend`=0, zero flag=0.
  - Outputs: `out_valid`=0, `out`=0, `out_last`=0, `out_zero`=0, `in_ready`=1.
  - `in_valid` is ignored in any cycle where `rst`=1.
- `rst` takes priority over all other events. A scan that is in progress is abandoned, and its remaining indices are discarded.
- Latency: a vector accepted at edge T gives `out_valid`=1 in the cycle after T, and the first index appears in that same cycle.
- With `out_ready` held at 1, a vector with N bits set occupies N consecutive `SCAN` cycles. `in_ready` rises in the cycle after the last transfer.
- Throughput is N+1 cycles per vector, or 2 cycles per zero vector. The block never accepts a new vector in the same cycle as a last-beat transfer.
- `out`, `out_last` and `out_zero` are functions of registered state only. There is no combinational path from `in` or `out_ready` to any output.

## Configuration
- `ENCODER_POPCOUNT_EN`
  - Defined: adds output port `out_count` [3:0], the number of set bits in the accepted vector (0–8). It is registered on accept and held constant across all beats of that vector. It is 0 in `IDLE` and after reset.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset and single bit:
  - Stimulus: apply `rst` for 2 cycles, check all outputs at reset values, then send `in`=8'b0000_1000 with `out_ready`=1.
  - Response: one beat with `out`=3, `out_last`=1; `in_ready` returns to 1 in the following cycle.
- Multi-bit vector, `LSB_FIRST`=1:
  - Stimulus: `in`=8'b1010_0101.
  - Response: beats `out`=0,2,5,7; `out_last` only on the 7 beat; `out_count`=4 on every beat if the macro is defined.
- Multi-bit vector, `LSB_FIRST`=0:
  - Stimulus: the same vector.
  - Response: beats 7,5,2,0 in that order.
- Zero vector:
  - Stimulus: `in`=8'h00.
  - Response: a single beat with `out`=0, `out_zero`=1, `out_last`=1.
- Backpressure:
  - Stimulus: `in`=8'hFF, `out_ready` toggled pseudo-randomly.
  - Response: 8 beats carrying indices 0..7 in order; outputs stable while stalled; `in_valid` held high during `SCAN` is not accepted.
- Reset mid-scan:
  - Stimulus: `in`=8'hF0, assert `rst` after 2 beats.
  - Response: next cycle `out_valid`=0 and `in_ready`=1. A following `in`=8'h01 yields a single beat with `out`=0 and no stale indices.

Source files
------------

// File: rtl/encoder_8to3_scan.sv
// rtl/encoder_8to3_scan.sv - sequential 8-to-3 priority encoder emitting one index per beat
// Define ENCODER_POPCOUNT_EN to add the out_count port (set-bit count of the accepted vector).
module encoder_8to3_scan #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out,
   output logic       out_last,
   output logic       out_zero
`ifdef ENCODER_POPCOUNT_EN
   ,
   output logic [3:0] out_count
`endif
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pend;
   logic       zero_flag;
   logic [2:0] idx;
   logic       single;
   logic       last;
   logic       xfer;

   always_comb begin
      idx = 3'd0;
      if (LSB_FIRST) begin
         for (int i = 7; i >= 0; i--)
            if (pend[i]) idx = 3'(i);
      end else begin
         for (int i = 0; i < 8; i++)
            if (pend[i]) idx = 3'(i);
      end
   end

   // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
   assign single = (pend != 8'd0) && ((pend & (pend - 8'd1)) == 8'd0);
   assign last   = zero_flag | single;
   assign xfer   = (state == SCAN) && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SCAN;
         SCAN:    if (out_ready && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == SCAN);
      out       = (state == SCAN) ? idx : 3'd0;
      out_last  = (state == SCAN) && last;
      out_zero  = (state == SCAN) && zero_flag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 8'd0;
         zero_flag <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         pend      <= in;
         zero_flag <= (in == 8'd0);
      end else if (xfer) begin
         if (last) begin
            pend      <= 8'd0;
            zero_flag <= 1'b0;
         end else begin
            pend      <= pend & ~(8'd1 << idx);
         end
      end
   end

`ifdef ENCODER_POPCOUNT_EN
   logic [3:0] cnt;
   logic [3:0] in_ones;

   always_comb begin
      in_ones = 4'd0;
      for (int i = 0; i < 8; i++)
         in_ones = in_ones + {3'd0, in[i]};
   end

   always_ff @(posedge clk) begin
      if (rst)                           cnt <= 4'd0;
      else if (state == IDLE && in_valid) cnt <= in_ones;
      else if (xfer && last)             cnt <= 4'd0;
   end

   assign out_count = cnt;
`endif

endmodule

// File: tb/tb_encoder_8to3_scan.sv
// tb/tb_encoder_8to3_scan.sv - randomized self-checking bench for encoder_8to3_scan, both priority orders
module tb_encoder_8to3_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_bus;
   logic       out_ready;

   logic       in_ready0, out_valid0, out_last0, out_zero0;
   logic [2:0] out0;
   logic       in_ready1, out_valid1, out_last1, out_zero1;
   logic [2:0] out1;
`ifdef ENCODER_POPCOUNT_EN
   logic [3:0] out_count0, out_count1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   encoder_8to3_scan #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready0), .in(in_bus),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out(out0), .out_last(out_last0), .out_zero(out_zero0)
`ifdef ENCODER_POPCOUNT_EN
      , .out_count(out_count0)
`endif
   );

   encoder_8to3_scan #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready1), .in(in_bus),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out(out1), .out_last(out_last1), .out_zero(out_zero1)
`ifdef ENCODER_POPCOUNT_EN
      , .out_count(out_count1)
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_idle();
      check("lsb_in_ready", int'(in_ready0), 1);
      check("lsb_out_valid", int'(out_valid0), 0);
      check("lsb_out", int'(out0), 0);
      check("lsb_out_last", int'(out_last0), 0);
      check("lsb_out_zero", int'(out_zero0), 0);
      check("msb_in_ready", int'(in_ready1), 1);
      check("msb_out_valid", int'(out_valid1), 0);
      check("msb_out", int'(out1), 0);
      check("msb_out_last", int'(out_last1), 0);
      check("msb_out_zero", int'(out_zero1), 0);
`ifdef ENCODER_POPCOUNT_EN
      check("lsb_count_idle", int'(out_count0), 0);
      check("msb_count_idle", int'(out_count1), 0);
`endif
   endtask

   task automatic check_beat(input int exp_lsb, input int exp_msb, input bit exp_last,
                             input bit exp_zero, input int exp_cnt);
      check("lsb_out_valid", int'(out_valid0), 1);
      check("lsb_in_ready", int'(in_ready0), 0);
      check("lsb_out", int'(out0), exp_lsb);
      check("lsb_out_last", int'(out_last0), int'(exp_last));
      check("lsb_out_zero", int'(out_zero0), int'(exp_zero));
      check("msb_out_valid", int'(out_valid1), 1);
      check("msb_out", int'(out1), exp_msb);
      check("msb_out_last", int'(out_last1), int'(exp_last));
      check("msb_out_zero", int'(out_zero1), int'(exp_zero));
`ifdef ENCODER_POPCOUNT_EN
      check("lsb_count", int'(out_count0), exp_cnt);
      check("msb_count", int'(out_count1), exp_cnt);
`else
      if (exp_cnt < 0) check("count_range", exp_cnt, 0);
`endif
   endtask

   // Send one vector and walk its beats; stall is the percent chance of holding out_ready low.
   task automatic run_vec(input logic [7:0] v, input int stall);
      int asc[$];
      int desc[$];
      int n;
      int k;
      int cyc;
      for (int b = 0; b < 8; b++)
         if (v[b]) asc.push_back(b);
      for (int b = 7; b >= 0; b--)
         if (v[b]) desc.push_back(b);
      if (asc.size() == 0) begin
         asc.push_back(0);
         desc.push_back(0);
      end
      n = asc.size();
      @(negedge clk);
      check_idle();
      in_valid  = 1'b1;
      in_bus    = v;
      out_ready = 1'b0;
      @(negedge clk);
      k   = 0;
      cyc = 0;
      while (k < n && cyc < 200) begin
         in_valid  = $urandom_range(0, 1) == 1;
         in_bus    = 8'($urandom_range(0, 255));
         check_beat(asc[k], desc[k], k == n - 1, v == 8'd0, $countones(v));
         out_ready = $urandom_range(0, 99) >= stall;
         @(negedge clk);
         if (out_ready) k++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("beats_done", k, n);
      check_idle();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_bus    = 8'hFF;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle();
      rst      = 1'b0;
      in_valid = 1'b0;

      run_vec(8'h08, 0);
      run_vec(8'hA5, 0);
      run_vec(8'h00, 0);
      run_vec(8'hFF, 50);

      // abandon a scan after two beats
      @(negedge clk);
      in_valid  = 1'b1;
      in_bus    = 8'hF0;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_first_lsb", int'(out0), 4);
      check("mid_first_msb", int'(out1), 7);
      @(negedge clk);
      check("mid_second_lsb", int'(out0), 5);
      check("mid_second_msb", int'(out1), 6);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b0;
      check_idle();
      run_vec(8'h01, 0);

      for (int t = 0; t < 40; t++) begin
         logic [7:0] v;
         v = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         run_vec(v, $urandom_range(0, 70));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
